// File: rtl/sprite_pixel_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_pixel_fetch_if : pixel timing, sprite control and RAM bus     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface sprite_pixel_fetch_if;
  logic        pixel_en;
  logic        display_en;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic        frame_start;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic        sprite_show;
  logic [18:0] bg_addr;
  logic [18:0] spr_addr;
  logic [3:0]  bg_data;
  logic [3:0]  spr_data;
  logic [3:0]  pix_idx;
  logic        pix_valid;
  logic        pix_is_sprite;

  modport master (
    output pixel_en, display_en, draw_x, draw_y, frame_start,
           sprite_x, sprite_y, sprite_show, bg_data, spr_data,
    input  bg_addr, spr_addr, pix_idx, pix_valid, pix_is_sprite
  );

  modport slave (
    input  pixel_en, display_en, draw_x, draw_y, frame_start,
           sprite_x, sprite_y, sprite_show, bg_data, spr_data,
    output bg_addr, spr_addr, pix_idx, pix_valid, pix_is_sprite
  );
endinterface
`default_nettype wire

// File: rtl/sprite_pixel_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_pixel_fetch : 3-stage background/sprite fetch and compositor  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sprite_pixel_fetch #(
  parameter int         SPR_W  = 35,
  parameter int         SPR_H  = 60,
  parameter logic [3:0] TRANSP = 4'h0
) (
  input wire clk,
  input wire rst_n,
  sprite_pixel_fetch_if.slave bus
);
  localparam logic [9:0]  c_SPR_W10 = 10'(SPR_W);
  localparam logic [9:0]  c_SPR_H10 = 10'(SPR_H);
  localparam logic [18:0] c_SPR_W19 = 19'(SPR_W);

  logic [9:0]  r_pos_x;
  logic [9:0]  r_pos_y;
  logic        r_show;
  logic [18:0] r_bg_addr;
  logic [18:0] r_spr_addr;
  logic        r_s1_valid;
  logic        r_s1_hit;
  logic        r_s2_valid;
  logic        r_s2_hit;
  logic [3:0]  r_pix_idx;
  logic        r_pix_valid;
  logic        r_pix_is_sprite;

  logic [8:0]  w_x_half;
  logic [8:0]  w_y_half;
  logic [18:0] w_bg_addr;
  logic [9:0]  w_dx;
  logic [9:0]  w_dy;
  logic        w_hit;
  logic [18:0] w_spr_addr;
  logic        w_use_spr;

  // y*320 as (y<<8)+(y<<6), each term padded to the full 19-bit width
  assign w_x_half  = bus.draw_x[9:1];
  assign w_y_half  = bus.draw_y[9:1];
  assign w_bg_addr = {2'b00, w_y_half, 8'h00} + {4'h0, w_y_half, 6'h00}
                   + {10'h000, w_x_half};

  // Unsigned wrap makes left/above-of-sprite coordinates huge, so they miss
  assign w_dx       = bus.draw_x - r_pos_x;
  assign w_dy       = bus.draw_y - r_pos_y;
  assign w_hit      = r_show & bus.display_en & (w_dx < c_SPR_W10) & (w_dy < c_SPR_H10);
  assign w_spr_addr = 19'(w_dy) * c_SPR_W19 + 19'(w_dx);

  assign w_use_spr  = r_s2_hit & (bus.spr_data != TRANSP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos_x <= '0;
      r_pos_y <= '0;
      r_show  <= 1'b0;
    end else if (bus.frame_start) begin
      r_pos_x <= bus.sprite_x;
      r_pos_y <= bus.sprite_y;
      r_show  <= bus.sprite_show;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bg_addr  <= '0;
      r_spr_addr <= '0;
    end else if (bus.pixel_en) begin
      r_bg_addr  <= bus.display_en ? w_bg_addr : 19'd0;
      r_spr_addr <= w_hit ? w_spr_addr : 19'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_hit   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_hit   <= 1'b0;
    end else begin
      r_s1_valid <= bus.pixel_en & bus.display_en;
      r_s1_hit   <= bus.pixel_en & w_hit;
      r_s2_valid <= r_s1_valid;
      r_s2_hit   <= r_s1_hit;
    end
  end

  // Stage 3: RAM data is valid here; outputs hold between valid pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_idx       <= '0;
      r_pix_valid     <= 1'b0;
      r_pix_is_sprite <= 1'b0;
    end else begin
      r_pix_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_pix_idx       <= w_use_spr ? bus.spr_data : bus.bg_data;
        r_pix_is_sprite <= w_use_spr;
      end
    end
  end

  assign bus.bg_addr       = r_bg_addr;
  assign bus.spr_addr      = r_spr_addr;
  assign bus.pix_idx       = r_pix_idx;
  assign bus.pix_valid     = r_pix_valid;
  assign bus.pix_is_sprite = r_pix_is_sprite;
endmodule
`default_nettype wire

// File: tb/tb_sprite_pixel_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sprite_pixel_fetch : directed, table-driven bench                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sprite_pixel_fetch;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  sprite_pixel_fetch_if bus ();

  sprite_pixel_fetch #(
    .SPR_W  (35),
    .SPR_H  (60),
    .TRANSP (4'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] spr_rom(input logic [18:0] a);
    return a[3:0] ^ 4'hA;
  endfunction

  function automatic logic [3:0] bg_rom(input logic [18:0] a);
    return a[3:0] ^ a[7:4] ^ 4'h3;
  endfunction

  // One-cycle read latency RAM models
  always @(posedge clk) begin
    bus.bg_data  <= bg_rom(bus.bg_addr);
    bus.spr_data <= spr_rom(bus.spr_addr);
  end

  typedef struct {
    int          due;
    logic [18:0] sa;
    logic [18:0] ba;
  } addr_exp_t;

  typedef struct {
    int         due;
    logic [3:0] idx;
    logic       is_spr;
  } pix_exp_t;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        de;
    logic        hit;
    logic [18:0] sa;
    logic [18:0] ba;
  } vec_t;

  addr_exp_t   aq[$];
  pix_exp_t    pq[$];
  logic [18:0] last_sa  = '0;
  logic [18:0] last_ba  = '0;
  logic [3:0]  last_idx = '0;
  logic        last_spr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: address stage one clock after capture, pixel three clocks after
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (aq.size() > 0 && aq[0].due == cyc) begin
        check("spr_addr", 32'(bus.spr_addr), 32'(aq[0].sa));
        check("bg_addr", 32'(bus.bg_addr), 32'(aq[0].ba));
        last_sa = aq[0].sa;
        last_ba = aq[0].ba;
        void'(aq.pop_front());
      end else begin
        check("spr_addr_hold", 32'(bus.spr_addr), 32'(last_sa));
        check("bg_addr_hold", 32'(bus.bg_addr), 32'(last_ba));
      end
      if (pq.size() > 0 && pq[0].due == cyc) begin
        check("pix_valid", 32'(bus.pix_valid), 32'd1);
        check("pix_idx", 32'(bus.pix_idx), 32'(pq[0].idx));
        check("pix_is_sprite", 32'(bus.pix_is_sprite), 32'(pq[0].is_spr));
        last_idx = pq[0].idx;
        last_spr = pq[0].is_spr;
        void'(pq.pop_front());
      end else begin
        check("pix_valid_idle", 32'(bus.pix_valid), 32'd0);
        check("pix_idx_hold", 32'(bus.pix_idx), 32'(last_idx));
        check("pix_is_sprite_hold", 32'(bus.pix_is_sprite), 32'(last_spr));
      end
    end
  end

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic de,
                     input logic fs, input logic hit, input logic [18:0] sa,
                     input logic [18:0] ba, input bit emit);
    addr_exp_t a;
    pix_exp_t  p;
    @(negedge clk);
    bus.pixel_en    = 1'b1;
    bus.draw_x      = x;
    bus.draw_y      = y;
    bus.display_en  = de;
    bus.frame_start = fs;
    a.due = cyc + 1;
    a.sa  = sa;
    a.ba  = ba;
    aq.push_back(a);
    if (emit && de) begin
      p.due    = cyc + 3;
      p.is_spr = hit && (spr_rom(sa) != 4'h0);
      p.idx    = p.is_spr ? spr_rom(sa) : bg_rom(ba);
      pq.push_back(p);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.pixel_en    = 1'b0;
      bus.frame_start = 1'b0;
    end
  endtask

  task automatic fstart(input logic [9:0] sx, input logic [9:0] sy, input logic show);
    @(negedge clk);
    bus.pixel_en    = 1'b0;
    bus.frame_start = 1'b1;
    bus.sprite_x    = sx;
    bus.sprite_y    = sy;
    bus.sprite_show = show;
    idle(1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bg_addr"}, 32'(bus.bg_addr), 32'd0);
    check({tag, "_spr_addr"}, 32'(bus.spr_addr), 32'd0);
    check({tag, "_pix_idx"}, 32'(bus.pix_idx), 32'd0);
    check({tag, "_pix_valid"}, 32'(bus.pix_valid), 32'd0);
    check({tag, "_pix_is_sprite"}, 32'(bus.pix_is_sprite), 32'd0);
  endtask

  vec_t vt[10];

  initial begin
    // Sprite at (100,50), 35x60, show=1
    vt[0] = '{10'd100, 10'd50,  1'b1, 1'b1, 19'd0,    19'd8050};
    vt[1] = '{10'd134, 10'd109, 1'b1, 1'b1, 19'd2099, 19'd17347};
    vt[2] = '{10'd135, 10'd109, 1'b1, 1'b0, 19'd0,    19'd17347};
    vt[3] = '{10'd134, 10'd110, 1'b1, 1'b0, 19'd0,    19'd17667};
    vt[4] = '{10'd99,  10'd50,  1'b1, 1'b0, 19'd0,    19'd8049};
    vt[5] = '{10'd110, 10'd50,  1'b1, 1'b1, 19'd10,   19'd8055};
    vt[6] = '{10'd101, 10'd51,  1'b1, 1'b1, 19'd36,   19'd8050};
    vt[7] = '{10'd639, 10'd479, 1'b1, 1'b0, 19'd0,    19'd76799};
    vt[8] = '{10'd100, 10'd50,  1'b0, 1'b0, 19'd0,    19'd0};
    vt[9] = '{10'd0,   10'd0,   1'b1, 1'b0, 19'd0,    19'd0};

    bus.pixel_en    = 1'b0;
    bus.display_en  = 1'b0;
    bus.draw_x      = '0;
    bus.draw_y      = '0;
    bus.frame_start = 1'b0;
    bus.sprite_x    = '0;
    bus.sprite_y    = '0;
    bus.sprite_show = 1'b0;

    #2 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    fstart(10'd100, 10'd50, 1'b1);
    for (int i = 0; i < 10; i++)
      pix(vt[i].x, vt[i].y, vt[i].de, 1'b0, vt[i].hit, vt[i].sa, vt[i].ba, 1'b1);
    idle(5);

    // Shadow registers only update on frame_start; coincident pixel sees old shadow
    bus.sprite_x = 10'd200;
    pix(10'd100, 10'd50, 1'b1, 1'b0, 1'b1, 19'd0, 19'd8050, 1'b1);
    pix(10'd200, 10'd50, 1'b1, 1'b0, 1'b0, 19'd0, 19'd8100, 1'b1);
    fstart(10'd200, 10'd50, 1'b1);
    pix(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 19'd0, 19'd8050, 1'b1);
    pix(10'd200, 10'd50, 1'b1, 1'b0, 1'b1, 19'd0, 19'd8100, 1'b1);
    bus.sprite_x = 10'd300;
    pix(10'd200, 10'd50, 1'b1, 1'b1, 1'b1, 19'd0, 19'd8100, 1'b1);
    pix(10'd300, 10'd50, 1'b1, 1'b0, 1'b1, 19'd0, 19'd8150, 1'b1);
    pix(10'd200, 10'd50, 1'b1, 1'b0, 1'b0, 19'd0, 19'd8100, 1'b1);
    idle(5);

    // Sprite hanging off the right edge; wrapped dx must miss
    fstart(10'd620, 10'd0, 1'b1);
    pix(10'd639, 10'd0,  1'b1, 1'b0, 1'b1, 19'd19,   19'd319,  1'b1);
    pix(10'd0,   10'd0,  1'b1, 1'b0, 1'b0, 19'd0,    19'd0,    1'b1);
    pix(10'd620, 10'd0,  1'b1, 1'b0, 1'b1, 19'd0,    19'd310,  1'b1);
    pix(10'd619, 10'd0,  1'b1, 1'b0, 1'b0, 19'd0,    19'd309,  1'b1);
    pix(10'd639, 10'd59, 1'b1, 1'b0, 1'b1, 19'd2084, 19'd9599, 1'b1);
    idle(5);

    // Full visible line back-to-back, then blanked pixels
    fstart(10'd100, 10'd50, 1'b1);
    for (int x = 0; x < 640; x++) begin
      logic hit;
      hit = (x >= 100) && (x < 135);
      pix(10'(x), 10'd50, 1'b1, 1'b0, hit, hit ? 19'(x - 100) : 19'd0,
          19'(25 * 320 + x / 2), 1'b1);
    end
    for (int i = 0; i < 3; i++)
      pix(10'(i), 10'd50, 1'b0, 1'b0, 1'b0, 19'd0, 19'd0, 1'b1);
    idle(5);

    // Asynchronous reset with pixels in flight: none may emerge
    pix(10'd100, 10'd50, 1'b1, 1'b0, 1'b1, 19'd0, 19'd8050, 1'b0);
    pix(10'd101, 10'd50, 1'b1, 1'b0, 1'b1, 19'd1, 19'd8050, 1'b0);
    pix(10'd102, 10'd50, 1'b1, 1'b0, 1'b1, 19'd2, 19'd8051, 1'b0);
    #2;
    rst_n        = 1'b0;
    bus.pixel_en = 1'b0;
    aq.delete();
    pq.delete();
    last_sa  = '0;
    last_ba  = '0;
    last_idx = '0;
    last_spr = 1'b0;
    #1 check_outputs_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    // Shadow cleared by reset: show=0 so the old sprite position no longer hits
    pix(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 19'd0, 19'd8050, 1'b1);
    pix(10'd5,   10'd5,  1'b1, 1'b0, 1'b0, 19'd0, 19'd642,  1'b1);
    idle(6);

    check("addr_queue_drained", 32'(aq.size()), 32'd0);
    check("pix_queue_drained", 32'(pq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sprite_pixel_fetch.md
SPRITE_PIXEL_FETCH -- requirements
Module: sprite_pixel_fetch

Interface
REQ-001 Parameter SPR_W, default 35, meaning sprite width in pixels; sprite ROM depth SHALL be SPR_W*SPR_H.
REQ-002 Parameter SPR_H, default 60, meaning sprite height in pixels.
REQ-003 Parameter TRANSP, default 4'h0, meaning sprite palette index treated as transparent.
REQ-004 Clk  input  1  system clock; single clock domain; all state SHALL be clocked on its rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 pixel_en  input  1  one-cycle strobe: DrawX/DrawY/display_en valid this cycle.
REQ-007 display_en  input  1  high when DrawX/DrawY is inside the 640x480 visible area.
REQ-008 DrawX, DrawY  input  10 each  current VGA pixel coordinate.
REQ-009 frame_start  input  1  one-cycle strobe at start of vertical blank.
REQ-010 sprite_x, sprite_y  input  10 each  requested sprite top-left position, screen pixels.
REQ-011 sprite_show  input  1  requested sprite visibility.
REQ-012 bg_addr, spr_addr  output  19 each  read addresses to background RAM (320x240, 4-bit) and sprite RAM.
REQ-013 bg_data, spr_data  input  4 each  RAM read data, valid exactly one Clk after the address is presented.
REQ-014 pix_idx  output  4  composited palette index.
REQ-015 pix_valid  output  1  one-cycle strobe: pix_idx valid.
REQ-016 pix_is_sprite  output  1  high when pix_idx came from the sprite.

Function
REQ-017 Shadow registers (pos_x, pos_y, show) SHALL load from sprite_x/sprite_y/sprite_show only on frame_start; all pixel computation SHALL use the shadow values.
REQ-018 If frame_start and pixel_en coincide, that pixel SHALL use the pre-update shadow values.
REQ-019 Stage 1 (registered on pixel_en): bg_addr = (DrawY>>1)*320 + (DrawX>>1), computed as (y<<8)+(y<<6)+x, 19-bit, no multiplier.
REQ-020 Stage 1: dx = DrawX - pos_x, dy = DrawY - pos_y, 10-bit unsigned wrap; hit = show & display_en & (dx < SPR_W) & (dy < SPR_H).
REQ-021 Stage 1: spr_addr = dy*SPR_W + dx when hit, else 0; bg_addr = 0 when display_en low.
REQ-022 bg_addr/spr_addr SHALL hold their value when pixel_en is low.
REQ-023 Stage 1 SHALL register valid = pixel_en & display_en plus hit; stage 2 SHALL delay both by one Clk to align with RAM data.
REQ-024 Stage 3: pix_idx = spr_data if stage-2 hit and spr_data != TRANSP, else bg_data; pix_is_sprite set accordingly; pix_valid = stage-2 valid.
REQ-025 Latency: pix_valid SHALL assert exactly 3 Clk after the pixel_en cycle; throughput one pixel per Clk (back-to-back pixel_en SHALL be supported).
REQ-026 Sprite partially off-screen (pos_x+SPR_W > 640, wrapping) SHALL display only in-range pixels; wrapped dx SHALL never produce a hit.
REQ-027 pix_idx and pix_is_sprite SHALL hold their last value while pix_valid is low.

Reset
REQ-028 Reset_n low SHALL immediately clear bg_addr, spr_addr, pix_idx, pix_valid, pix_is_sprite, all pipeline valid/hit flags, and shadow pos_x/pos_y/show to 0.
REQ-029 Reset mid-pipeline SHALL discard in-flight pixels; no pix_valid SHALL assert until 3 Clk after the first pixel_en following Reset_n release.

Verification
REQ-030 Reset, frame_start with sprite (100,50), show=1; pixel_en at (100,50) -> cycle+1 spr_addr=0, bg_addr=25*320+50=8050; cycle+3 pix_valid=1, pix_idx=spr_data if not 0.
REQ-031 Same sprite, pixel (134,109) -> spr_addr=59*35+34=2099, hit; pixel (135,109) -> no hit, spr_addr=0, pix_idx=bg_data, pix_is_sprite=0.
REQ-032 Hit pixel with spr_data=4'h0 -> pix_idx=bg_data, pix_is_sprite=0.
REQ-033 sprite_x changed to 200 without frame_start -> pixel (100,50) still hits; after frame_start, (100,50) misses and (200,50) hits; coincident frame_start+pixel_en uses old position.
REQ-034 640 consecutive pixel_en with display_en=1 -> 640 consecutive pix_valid pulses, each 3 Clk delayed; display_en=0 pixels -> no pix_valid.
REQ-035 Reset_n pulsed low while 3 pixels in flight -> outputs 0 asynchronously, none of those pixels emitted.
